// File: rtl/pipeline_hazard_scoreboard_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
package PipelineHazardCtrl;

    // EXE operand source select
    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_WB  = 2'b01,
        FWD_DM  = 2'b10
    } fwd_sel_t;

    // A consumer depends on a producer when it really reads a non-zero register the producer writes.
    function automatic logic dep_match(input int unsigned src, input int unsigned dst,
                                       input logic use_src);
        return use_src && (src != 0) && (src == dst);
    endfunction

endpackage

// File: rtl/md_busy_tracker.sv
// Counts down the mult/div latency so HI/LO consumers know when the result is ready.
module md_busy_tracker
    import PipelineHazardCtrl::*;
#(
    parameter int unsigned MD_LAT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic md_start,
    output logic md_busy
);

    localparam int unsigned CntW = $clog2(MD_LAT + 1);

    logic [CntW-1:0] md_cnt_q, md_cnt_d;

    // Reload on issue, otherwise count down to zero and hold.
    always_comb begin
        md_cnt_d = md_cnt_q;
        if (md_start) begin
            md_cnt_d = CntW'(MD_LAT);
        end else if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - 1'b1;
        end
    end

    // Countdown register; reset clears a pending result immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            md_cnt_q <= '0;
        end else begin
            md_cnt_q <= md_cnt_d;
        end
    end

    assign md_busy = (md_cnt_q != '0);

endmodule

// File: rtl/pipeline_hazard_scoreboard.sv
// Hazard controller for a 5-stage MIPS pipeline with a multi-cycle mult/div unit:
// operand forwarding, load-use / branch / HI-LO stalls, taken-branch flush, perf counters.
module pipeline_hazard_scoreboard
    import PipelineHazardCtrl::*;
#(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned MD_LAT = 4,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rs_decode,
    input  logic [REG_AW-1:0] rt_decode,
    input  logic              use_rs_decode,
    input  logic              use_rt_decode,
    input  logic              is_branch_decode,
    input  logic              branch_taken_decode,
    input  logic              md_start_decode,
    input  logic              md_read_decode,
    input  logic [REG_AW-1:0] rs_exe,
    input  logic [REG_AW-1:0] rt_exe,
    input  logic [REG_AW-1:0] wreg_dst_exe,
    input  logic              reg_we_exe,
    input  logic              mem_to_reg_exe,
    input  logic              md_start_exe,
    input  logic [REG_AW-1:0] wreg_dst_dm,
    input  logic              reg_we_dm,
    input  logic              mem_to_reg_dm,
    input  logic [REG_AW-1:0] wreg_dst_wrbck,
    input  logic              reg_we_wrbck,
    input  logic              perf_clr,
    output logic              stall_fetch,
    output logic              stall_decode,
    output logic              clear_exe,
    output logic              flush_decode,
    output fwd_sel_t          forward_srca_sel_exe,
    output fwd_sel_t          forward_srcb_sel_exe,
    output logic              md_busy,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  md_stall_cycles
);

    logic lw_stall, br_stall, md_stall, stall;
    logic dep_exe, dep_dm;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] md_stall_cycles_q, md_stall_cycles_d;

    // DM is the younger producer, so it wins over WB.
    function automatic fwd_sel_t fwd_pick(input logic [REG_AW-1:0] src,
                                          input logic [REG_AW-1:0] dst_dm, input logic we_dm,
                                          input logic [REG_AW-1:0] dst_wb, input logic we_wb);
        if (we_dm && dep_match(32'(src), 32'(dst_dm), 1'b1)) begin
            return FWD_DM;
        end else if (we_wb && dep_match(32'(src), 32'(dst_wb), 1'b1)) begin
            return FWD_WB;
        end
        return FWD_REG;
    endfunction

    md_busy_tracker #(
        .MD_LAT(MD_LAT)
    ) u_md_busy_tracker (
        .clk     (clk),
        .rst     (rst),
        .md_start(md_start_exe),
        .md_busy (md_busy)
    );

    // Forwarding selects for both EXE operands.
    always_comb begin
        forward_srca_sel_exe = fwd_pick(rs_exe, wreg_dst_dm, reg_we_dm,
                                        wreg_dst_wrbck, reg_we_wrbck);
        forward_srcb_sel_exe = fwd_pick(rt_exe, wreg_dst_dm, reg_we_dm,
                                        wreg_dst_wrbck, reg_we_wrbck);
    end

    // Stall and flush decisions for the decode stage.
    always_comb begin
        dep_exe  = dep_match(32'(rs_decode), 32'(wreg_dst_exe), use_rs_decode) ||
                   dep_match(32'(rt_decode), 32'(wreg_dst_exe), use_rt_decode);
        dep_dm   = dep_match(32'(rs_decode), 32'(wreg_dst_dm), use_rs_decode) ||
                   dep_match(32'(rt_decode), 32'(wreg_dst_dm), use_rt_decode);
        lw_stall = reg_we_exe && mem_to_reg_exe && dep_exe;
        // Branches compare in ID, so even ALU results in EXE are too late to forward.
        br_stall = is_branch_decode &&
                   ((reg_we_exe && dep_exe) || (reg_we_dm && mem_to_reg_dm && dep_dm));
        md_stall = (md_read_decode && (md_busy || md_start_exe)) ||
                   (md_start_decode && md_busy);
        stall    = lw_stall || br_stall || md_stall;
    end

    assign stall_fetch  = stall;
    assign stall_decode = stall;
    assign clear_exe    = stall;
    // A stalled branch is re-evaluated next cycle, so it must not flush yet.
    assign flush_decode = branch_taken_decode && !stall;

    // Saturating perf counter next-state; clear has priority.
    always_comb begin
        stall_cycles_d    = stall_cycles_q;
        md_stall_cycles_d = md_stall_cycles_q;
        if (perf_clr) begin
            stall_cycles_d    = '0;
            md_stall_cycles_d = '0;
        end else begin
            if (stall && (stall_cycles_q != '1)) begin
                stall_cycles_d = stall_cycles_q + 1'b1;
            end
            if (md_stall && (md_stall_cycles_q != '1)) begin
                md_stall_cycles_d = md_stall_cycles_q + 1'b1;
            end
        end
    end

    // Perf counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles_q    <= '0;
            md_stall_cycles_q <= '0;
        end else begin
            stall_cycles_q    <= stall_cycles_d;
            md_stall_cycles_q <= md_stall_cycles_d;
        end
    end

    assign stall_cycles    = stall_cycles_q;
    assign md_stall_cycles = md_stall_cycles_q;

endmodule
